// File: rtl/fp_map_ctrl_pkg.sv
// Shared constants, select-code legality check and channel state type
// for the front-panel output mapper controller.
package fp_map_pkg;

  localparam logic [5:0] SEL_OFF       = 6'h00;
  localparam int         FPS_NUM       = 6;
  localparam int         FPS_BASE_ADDR = 32;

  // Legal select code ranges
  localparam logic [5:0] PULSE_LO = 6'd11;
  localparam logic [5:0] PULSE_HI = 6'd24;
  localparam logic [5:0] DBUS_LO  = 6'd32;
  localparam logic [5:0] DBUS_HI  = 6'd39;
  localparam logic [5:0] REV402   = 6'd43;
  localparam logic [5:0] REV396   = 6'd44;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_BLANK = 1'b1
  } ch_state_t;

  // OFF, pulses, databus lines and the two revolution clocks are accepted
  function automatic logic fps_code_legal(input logic [5:0] code);
    return (code == SEL_OFF)
        || ((code >= PULSE_LO) && (code <= PULSE_HI))
        || ((code >= DBUS_LO)  && (code <= DBUS_HI))
        || (code == REV402)
        || (code == REV396);
  endfunction

endpackage

// File: rtl/fp_map_ctrl_if.sv
// Register bus between software and the front-panel mapper controller.
interface fp_map_ctrl_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [5:0] wr_data;
  logic [7:0] rd_addr;
  logic [5:0] rd_data;
  logic       err_illegal;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, err_illegal
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, err_illegal
  );
endinterface

// File: rtl/fp_map_ctrl_chan_seq.sv
// One front-panel channel: IDLE/BLANK sequencer with guard counter,
// pending (last accepted) select and active (committed) select.
module fp_chan_seq
  import fp_map_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,       // legal write addressed to this channel
  input  logic [5:0] i_code,
  output logic       o_blank,
  output logic [5:0] o_active,
  output logic [5:0] o_pending
);

  localparam logic [3:0] CNT_LOAD = 4'(GUARD_CYCLES - 1);

  ch_state_t  r_state;
  logic [3:0] r_cnt;
  logic [5:0] r_active;
  logic [5:0] r_pending;

  // Channel FSM: any change of select (or a rewrite while blanking)
  // restarts the guard period; the select is committed when it expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CH_IDLE;
      r_cnt     <= '0;
      r_active  <= SEL_OFF;
      r_pending <= SEL_OFF;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_wr) begin
            r_pending <= i_code;
            if (i_code != r_active) begin
              r_cnt   <= CNT_LOAD;
              r_state <= CH_BLANK;
            end
          end
        end
        CH_BLANK: begin
          if (i_wr) begin
            r_pending <= i_code;
            r_cnt     <= CNT_LOAD;
          end else if (r_cnt == 4'd0) begin
            r_active <= r_pending;
            r_state  <= CH_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= CH_IDLE;
      endcase
    end
  end

  assign o_blank   = (r_state == CH_BLANK);
  assign o_active  = r_active;
  assign o_pending = r_pending;

endmodule

// File: rtl/fp_map_ctrl.sv
// Front-panel mapper controller: decodes FPS1..FPS6 register writes,
// rejects illegal codes, sequences each channel through a blanking
// guard period, and drives registered, enable-gated selects.
module fp_map_ctrl
  import fp_map_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int BASE_ADDR    = FPS_BASE_ADDR
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_map_ctrl_if.slave bus,
  input  logic         out_enable,
  output logic [5:0]   FPS1,
  output logic [5:0]   FPS2,
  output logic [5:0]   FPS3,
  output logic [5:0]   FPS4,
  output logic [5:0]   FPS5,
  output logic [5:0]   FPS6,
  output logic [5:0]   busy
);

  logic [FPS_NUM-1:0] w_sel;
  logic [FPS_NUM-1:0] w_blank;
  logic [5:0]         w_active  [FPS_NUM];
  logic [5:0]         w_pending [FPS_NUM];
  logic               w_legal;
  logic               w_hit;
  logic [5:0]         w_rd_mux;

  logic [5:0]         r_fps [FPS_NUM];
  logic [5:0]         r_busy;
  logic [5:0]         r_rd_data;
  logic               r_err;

  assign w_legal = fps_code_legal(bus.wr_data);
  assign w_hit   = |w_sel;

  genvar gi;
  generate
    for (gi = 0; gi < FPS_NUM; gi++) begin : g_chan
      assign w_sel[gi] = bus.wr_en && (bus.wr_addr == 8'(BASE_ADDR + gi));

      fp_chan_seq #(
        .GUARD_CYCLES (GUARD_CYCLES)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (w_sel[gi] && w_legal),
        .i_code    (bus.wr_data),
        .o_blank   (w_blank[gi]),
        .o_active  (w_active[gi]),
        .o_pending (w_pending[gi])
      );

      // Output stage: OFF while blanking or globally disabled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fps[gi]  <= SEL_OFF;
          r_busy[gi] <= 1'b0;
        end else begin
          r_fps[gi]  <= (out_enable && !w_blank[gi]) ? w_active[gi] : SEL_OFF;
          r_busy[gi] <= w_blank[gi];
        end
      end
    end
  endgenerate

  // Readback select: pending code of the addressed channel, 0 elsewhere
  always_comb begin
    w_rd_mux = SEL_OFF;
    for (int i = 0; i < FPS_NUM; i++) begin
      if (bus.rd_addr == 8'(BASE_ADDR + i)) w_rd_mux = w_pending[i];
    end
  end

  // Registered readback and one-cycle error pulse on rejected writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= SEL_OFF;
      r_err     <= 1'b0;
    end else begin
      r_rd_data <= w_rd_mux;
      r_err     <= w_hit && !w_legal;
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.err_illegal = r_err;
  assign busy            = r_busy;
  assign FPS1            = r_fps[0];
  assign FPS2            = r_fps[1];
  assign FPS3            = r_fps[2];
  assign FPS4            = r_fps[3];
  assign FPS5            = r_fps[4];
  assign FPS6            = r_fps[5];

endmodule

// File: doc/fp_map_ctrl.md
Name: fp_map_ctrl

Overview:
- Register-side controller for the front-panel output mapper. It owns the six 6-bit front-panel source selects (FPS1..FPS6, registers 32..37) and drives them to the combinational mapper.
- Every select change is sequenced glitch-free: the channel is blanked (select forced to OFF = 6'h00, mapper outputs 0) for a guard period, then the new select is committed.
- Illegal select codes are rejected. Software readback is provided.

Parameters:
- GUARD_CYCLES, 4, number of cycles a channel is held at OFF before a new select is committed; legal range 1..15.
- BASE_ADDR, 32, register address of FPS1; FPSn sits at BASE_ADDR+n-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  register write strobe, one cycle per write
- wr_addr  in  8  register write address
- wr_data  in  6  select code to write
- rd_addr  in  8  register read address
- rd_data  out  6  readback of pending select for rd_addr; 0 for addresses outside 32..37
- out_enable  in  1  global front-panel enable; low forces all FPS outputs to OFF
- FPS1..FPS6  out  6 each  committed selects to the mapper
- busy  out  6  bit n-1 high while channel n is blanking
- err_illegal  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (async assert, sync release): FPSn=0, active[n]=0, pending[n]=0, busy=0, rd_data=0, err_illegal=0, all channels in IDLE.
- Legal codes: 0 (OFF), 11..24 (pulses 0..13), 32..39 (Databus 0..7), 43, 44 (revolution clocks). All other codes are illegal.
- Write decode: wr_en=1 and wr_addr in BASE_ADDR..BASE_ADDR+5 selects a channel. Any other address is ignored, with no error.
- Illegal code to a valid address: nothing changes, and err_illegal=1 in the following cycle.
- Per-channel FSM, states IDLE and BLANK:
  - IDLE, legal write with code != active: pending=code, cnt=GUARD_CYCLES-1, go to BLANK.
  - IDLE, legal write with code == active: pending=code, no blanking, FPSn unchanged.
  - BLANK: FPSn=0 and busy=1. cnt decrements each cycle.
  - BLANK, cnt==0: active=pending, return to IDLE. FPSn=active from the next cycle.
  - BLANK, new legal write: pending=new code and cnt reloads to GUARD_CYCLES-1, even if the new code equals the old active.
- Timing: write sampled at edge T. FPSn=0 during cycles T+1..T+GUARD_CYCLES. FPSn=new code from cycle T+GUARD_CYCLES+1. busy is high over the same window as the blanking.
- Writing 0 (OFF) follows the same path: blank, then commit 0.
- out_enable=0: all FPSn=0 combinationally gated at the registered output stage, i.e. FPSn=0 in the cycle after out_enable is sampled low. The FSMs and counters keep running, so a pending commit still completes internally. On re-enable, FPSn=active from the next cycle.
- Readback: rd_data is registered, one-cycle latency, and returns pending[n].
- Same-cycle read and write to one address: rd_data returns the value before the write.
- Only one write per cycle exists, so channels never contend. Channels run independently; several may blank concurrently.
- Reset mid-BLANK: channel returns to IDLE with active=0 immediately on rst_n low.

Decomposition:
- Package fp_map_pkg:
  - constants SEL_OFF=6'h00, FPS_NUM=6, FPS_BASE_ADDR=32;
  - a function fps_code_legal(code) returning 1 for the legal set;
  - localparams for the code range bounds (PULSE_LO=11, PULSE_HI=24, DBUS_LO=32, DBUS_HI=39, REV402=43, REV396=44).
- Sub-module fp_chan_seq: one channel's IDLE/BLANK FSM, guard counter, pending and active registers. Instantiated six times by fp_map_ctrl.
- fp_map_ctrl keeps the address decode, legality check, err_illegal, readback mux and out_enable gating.

Test Plan:
- Reset release, no writes -> all FPSn=0, busy=0, rd_data(32..37)=0.
- Write 13 to addr 32 at edge T, GUARD=4 -> FPS1=0 and busy[0]=1 for T+1..T+4; FPS1=13 from T+5; FPS2..6 stay 0.
- FPS3=20 committed; write 33 to addr 34, then write 36 to addr 34 two cycles later -> FPS3=0 continuously until 4 cycles after the second write, then 36; value 33 never appears.
- Write 40 to addr 35 -> err_illegal pulses once the next cycle; FPS4, pending and rd_data(35) unchanged. Write 16 to addr 38 -> no change, no error.
- FPS2=43 committed, out_enable low for 10 cycles while writing 44 to addr 33 -> FPS2=0 throughout; after re-enable FPS2=44 the next cycle.
- FPS6 mid-BLANK (pending 39), assert rst_n low -> FPS6=0, busy=0 immediately; after release FPS6 stays 0 and rd_data(37)=0.
